// File: rtl/logic_unit_serial.sv
// -----------------------------------------------------------------------------
// logic_unit_serial
//
// Slice-serial bitwise logic unit with status flags. Accepts one operand pair
// and an opcode over a valid/ready handshake. It evaluates SLICE bits per
// clock, starting at the least significant slice, so an operation takes
// N = WIDTH/SLICE compute cycles. The finished result and its flags are held
// until the consumer takes them.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   SLICE  bits evaluated per cycle (must divide WIDTH exactly)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operand pair + opcode present
//   in_ready     unit idle and able to accept
//   a, b         operands
//   op           000 AND, 001 OR, 010 XOR, 011 XNOR,
//                100 NAND, 101 NOR, 110 NOT a, 111 PASS a
//   out_valid    result and flags valid
//   out_ready    consumer takes the result
//   result       operation result
//   zero_flag    result == 0
//   neg_flag     result MSB
//   parity_flag  XOR-reduction of result (1 = odd number of ones)
//   busy         unit is not idle
// -----------------------------------------------------------------------------
module logic_unit_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             parity_flag,
    output logic             busy
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_parity;
    logic               r_out_valid;

    // Bit offset of the slice being evaluated this cycle.
    logic [31:0]        w_shift;
    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_slice_res;
    logic [WIDTH-1:0]   w_slice_mask;
    logic [WIDTH-1:0]   w_slice_val;
    logic [WIDTH-1:0]   w_next_result;

    assign w_shift   = 32'(r_cnt) * 32'(SLICE);
    // One shifter per operand selects the active slice, so the per-cycle
    // logic stays SLICE bits wide regardless of WIDTH.
    assign w_a_slice = SLICE'(r_a >> w_shift);
    assign w_b_slice = SLICE'(r_b >> w_shift);

    // Purely bitwise: each bit of the slice depends only on its own a/b bit.
    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            always_comb begin
                w_slice_res[gi] = 1'b0;
                case (r_op)
                    3'b000:  w_slice_res[gi] =   w_a_slice[gi] & w_b_slice[gi];
                    3'b001:  w_slice_res[gi] =   w_a_slice[gi] | w_b_slice[gi];
                    3'b010:  w_slice_res[gi] =   w_a_slice[gi] ^ w_b_slice[gi];
                    3'b011:  w_slice_res[gi] = ~(w_a_slice[gi] ^ w_b_slice[gi]);
                    3'b100:  w_slice_res[gi] = ~(w_a_slice[gi] & w_b_slice[gi]);
                    3'b101:  w_slice_res[gi] = ~(w_a_slice[gi] | w_b_slice[gi]);
                    3'b110:  w_slice_res[gi] =  ~w_a_slice[gi];
                    default: w_slice_res[gi] =   w_a_slice[gi];
                endcase
            end
        end
    endgenerate

    // Merge the freshly computed slice into the result word. The flags are
    // taken from this merged value on the final slice, so they reflect the
    // completed result in the same edge that raises out_valid.
    assign w_slice_mask  = WIDTH'({SLICE{1'b1}}) << w_shift;
    assign w_slice_val   = WIDTH'(w_slice_res) << w_shift;
    assign w_next_result = (r_result & ~w_slice_mask) | w_slice_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_parity    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_result <= w_next_result;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt       <= '0;
                        r_zero      <= ~|w_next_result;
                        r_neg       <= w_next_result[WIDTH-1];
                        r_parity    <= ^w_next_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // New requests are ignored here; result and flags hold
                    // until the consumer takes them.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE) && !rst;
    assign busy        = (r_state != ST_IDLE);
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign zero_flag   = r_zero;
    assign neg_flag    = r_neg;
    assign parity_flag = r_parity;

endmodule

// File: tb/tb_logic_unit_serial.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_serial
//
// Directed testbench for logic_unit_serial. Two instances: WIDTH=16/SLICE=4
// and WIDTH=8/SLICE=8. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_logic_unit_serial;

    logic        clk;
    logic        rst;

    // 16-bit / 4-bit slice instance
    logic        in_valid_16;
    logic        in_ready_16;
    logic [15:0] a_16;
    logic [15:0] b_16;
    logic [2:0]  op_16;
    logic        out_valid_16;
    logic        out_ready_16;
    logic [15:0] result_16;
    logic        zero_16;
    logic        neg_16;
    logic        parity_16;
    logic        busy_16;

    // 8-bit / 8-bit slice instance
    logic        in_valid_8;
    logic        in_ready_8;
    logic [7:0]  a_8;
    logic [7:0]  b_8;
    logic [2:0]  op_8;
    logic        out_valid_8;
    logic        out_ready_8;
    logic [7:0]  result_8;
    logic        zero_8;
    logic        neg_8;
    logic        parity_8;
    logic        busy_8;

    int checks_cnt;
    int errors_cnt;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic_unit_serial #(.WIDTH(16), .SLICE(4)) u_dut_16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_16),
        .in_ready    (in_ready_16),
        .a           (a_16),
        .b           (b_16),
        .op          (op_16),
        .out_valid   (out_valid_16),
        .out_ready   (out_ready_16),
        .result      (result_16),
        .zero_flag   (zero_16),
        .neg_flag    (neg_16),
        .parity_flag (parity_16),
        .busy        (busy_16)
    );

    logic_unit_serial #(.WIDTH(8), .SLICE(8)) u_dut_8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_8),
        .in_ready    (in_ready_8),
        .a           (a_8),
        .b           (b_8),
        .op          (op_8),
        .out_valid   (out_valid_8),
        .out_ready   (out_ready_8),
        .result      (result_8),
        .zero_flag   (zero_8),
        .neg_flag    (neg_8),
        .parity_flag (parity_8),
        .busy        (busy_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid on the 16-bit instance; returns edges waited.
    task automatic wait_valid_16(output int edges);
        edges = 0;
        while (!out_valid_16 && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    // One full transaction on the 16-bit instance with out_ready held high.
    task automatic run_16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [2:0] opv, input logic [15:0] exp_res,
                          input logic exp_z, input logic exp_n, input logic exp_p);
        int edges;
        check_val({tag, "_in_ready"}, 32'(in_ready_16), 32'd1);
        a_16         = av;
        b_16         = bv;
        op_16        = opv;
        in_valid_16  = 1'b1;
        out_ready_16 = 1'b1;
        tick();                       // accept edge
        in_valid_16  = 1'b0;
        a_16         = 16'h0000;
        b_16         = 16'h0000;
        op_16        = 3'b000;
        wait_valid_16(edges);
        check_val({tag, "_latency"}, 32'(edges), 32'd4);
        check_val({tag, "_result"}, 32'(result_16), 32'(exp_res));
        check_val({tag, "_flags"}, {29'd0, zero_16, neg_16, parity_16},
                  {29'd0, exp_z, exp_n, exp_p});
        tick();                       // handshake edge
        check_val({tag, "_idle_after"}, {30'd0, in_ready_16, out_valid_16}, 32'b10);
        $display("txn %s a=%h b=%h op=%b result=%h z=%b n=%b p=%b lat=%0d",
                 tag, av, bv, opv, result_16, zero_16, neg_16, parity_16, edges);
    endtask

    initial begin
        int edges;
        checks_cnt   = 0;
        errors_cnt   = 0;
        rst          = 1'b1;
        in_valid_16  = 1'b0;
        a_16         = '0;
        b_16         = '0;
        op_16        = '0;
        out_ready_16 = 1'b0;
        in_valid_8   = 1'b0;
        a_8          = '0;
        b_8          = '0;
        op_8         = '0;
        out_ready_8  = 1'b0;

        // Reset state
        #12;
        check_val("rst_state16", {27'd0, out_valid_16, busy_16, zero_16, neg_16, parity_16}, 32'd0);
        check_val("rst_result16", 32'(result_16), 32'd0);
        check_val("rst_state8", {24'd0, result_8}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("rst_release_ready", {30'd0, in_ready_16, in_ready_8}, 32'b11);
        tick();

        // Main function, every opcode
        run_16("xor_basic", 16'h00FF, 16'h0F0F, OP_XOR,  16'h0FF0, 1'b0, 1'b0, 1'b0);
        run_16("xor_zero",  16'hA5A5, 16'hA5A5, OP_XOR,  16'h0000, 1'b1, 1'b0, 1'b0);
        run_16("nand",      16'hFFFF, 16'h0001, OP_NAND, 16'hFFFE, 1'b0, 1'b1, 1'b1);
        run_16("nor",       16'h0000, 16'h8000, OP_NOR,  16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_16("and",       16'hF0F0, 16'h3C3C, OP_AND,  16'h3030, 1'b0, 1'b0, 1'b0);
        run_16("or",        16'h8001, 16'h0100, OP_OR,   16'h8101, 1'b0, 1'b1, 1'b1);
        run_16("xnor",      16'h1234, 16'h1234, OP_XNOR, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        run_16("nota",      16'h0F00, 16'hFFFF, OP_NOTA, 16'hF0FF, 1'b0, 1'b1, 1'b0);
        run_16("pass",      16'h0007, 16'hFFFF, OP_PASS, 16'h0007, 1'b0, 1'b0, 1'b1);

        // Backpressure: AND 0x1234 & 0x00FF = 0x0034 (3 ones)
        a_16         = 16'h1234;
        b_16         = 16'h00FF;
        op_16        = OP_AND;
        in_valid_16  = 1'b1;
        out_ready_16 = 1'b0;
        tick();
        in_valid_16  = 1'b0;
        wait_valid_16(edges);
        check_val("bp_latency", 32'(edges), 32'd4);
        // New request presented while the result is waiting
        a_16        = 16'h5555;
        b_16        = 16'hAAAA;
        op_16       = OP_OR;
        in_valid_16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_hold", {12'd0, in_ready_16, out_valid_16, zero_16, neg_16, result_16},
                      {12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0034});
            check_val("bp_parity", 32'(parity_16), 32'd1);
            $display("txn bp_hold cycle=%0d result=%h out_valid=%b in_ready=%b",
                     i, result_16, out_valid_16, in_ready_16);
            tick();
        end
        out_ready_16 = 1'b1;
        tick();                       // handshake edge
        check_val("bp_release", {30'd0, in_ready_16, out_valid_16}, 32'b10);
        check_val("bp_result_kept", 32'(result_16), 32'h0034);
        tick();                       // pending request accepted here
        in_valid_16 = 1'b0;
        check_val("bp_accept_busy", {30'd0, busy_16, in_ready_16}, 32'b10);
        wait_valid_16(edges);
        check_val("bp_next_latency", 32'(edges), 32'd4);
        check_val("bp_next_result", 32'(result_16), 32'hFFFF);
        $display("txn bp_next result=%h lat=%0d", result_16, edges);
        tick();

        // Reset mid-BUSY after slice 2: OR 0xFFFF | 0 makes partial result nonzero
        a_16         = 16'hFFFF;
        b_16         = 16'h0000;
        op_16        = OP_OR;
        in_valid_16  = 1'b1;
        out_ready_16 = 1'b1;
        tick();                       // accept
        in_valid_16  = 1'b0;
        tick();                       // slice 0
        tick();                       // slice 1
        tick();                       // slice 2
        check_val("abort_pre_busy", 32'(busy_16), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_state", {27'd0, out_valid_16, busy_16, zero_16, neg_16, parity_16}, 32'd0);
        check_val("abort_result", 32'(result_16), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        check_val("abort_ready", 32'(in_ready_16), 32'd1);
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid_16 || busy_16) edges++;
        end
        check_val("abort_no_valid", 32'(edges), 32'd0);
        $display("txn abort result=%h busy=%b out_valid=%b", result_16, busy_16, out_valid_16);

        // 8-bit single-slice instance: NOT 0x3C = 0xC3
        check_val("w8_in_ready", 32'(in_ready_8), 32'd1);
        a_8         = 8'h3C;
        b_8         = 8'hFF;
        op_8        = OP_NOTA;
        in_valid_8  = 1'b1;
        out_ready_8 = 1'b0;
        tick();                       // accept
        in_valid_8  = 1'b0;
        edges = 0;
        while (!out_valid_8 && edges < 20) begin
            tick();
            edges++;
        end
        check_val("w8_latency", 32'(edges), 32'd1);
        check_val("w8_result", 32'(result_8), 32'hC3);
        check_val("w8_flags", {29'd0, zero_8, neg_8, parity_8}, 32'b010);
        $display("txn w8_not a=3c result=%h z=%b n=%b p=%b lat=%0d",
                 result_8, zero_8, neg_8, parity_8, edges);
        out_ready_8 = 1'b1;
        tick();
        check_val("w8_idle_after", {30'd0, in_ready_8, out_valid_8}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
- Parametrised, slice-serial bitwise logic unit with status flags. It is the sequential successor to the fixed 16-bit single-op XOR block in the ALU datapath.
- Accepts one operand pair plus an opcode through a valid/ready handshake. It processes SLICE bits per cycle and holds the result and flags until the consumer takes them.
- Sits beside the adder/shifter units under the ALU controller. It trades latency for small, width-independent logic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 1.
- SLICE, 4, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/SLICE cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair and opcode present.
- in_ready  output  1  unit can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT a, 111 PASS a.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  operation result.
- zero_flag  output  1  result == 0.
- neg_flag  output  1  result[WIDTH-1].
- parity_flag  output  1  XOR-reduction of result (1 = odd number of ones).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE; result=0; all flags=0; out_valid=0; busy=0; slice counter=0. in_ready=1 once rst is low.
- Reset mid-operation aborts the operation. No out_valid is produced and captured operands are discarded.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid && in_ready: register a, b and op; clear the slice counter; go to BUSY.
  - op is not sampled again until the next accept.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge computes slice k = counter: result[k*SLICE +: SLICE] = f(op, a_reg slice, b_reg slice). Then the counter increments.
  - Bits outside the slices written so far are don't-care while BUSY. The bench must not check result before out_valid.
  - On the edge that writes slice N-1: go to DONE, reset the counter to 0, and register the flags from the completed result.
  - out_valid rises N edges after the accept edge.
  - With SLICE=WIDTH, N=1: the edge after accept writes the whole result.
- DONE:
  - out_valid=1, in_ready=0.
  - result and flags are held stable while out_ready=0.
  - in_valid is ignored. No capture and no overwrite happens in this state.
  - On an edge with out_valid && out_ready: go to IDLE, out_valid=0. result and flags keep their values until the next DONE.
- Throughput is one operation per N+2 cycles minimum (accept, N compute, handshake). Accepting in the same cycle as the output handshake is not supported.
- Opcode function is purely bitwise per bit position. There is no carry between slices.
- NOT and PASS ignore b.

Test Plan:
- WIDTH=16, SLICE=4: accept a=0x00FF, b=0x0F0F, op=XOR, out_ready=1 -> out_valid exactly 4 edges after accept; result=0x0FF0, zero=0, neg=0, parity=0; in_ready=1 the cycle after the handshake.
- a=0xA5A5, b=0xA5A5, op=XOR -> result=0x0000, zero=1, neg=0, parity=0.
- a=0xFFFF, b=0x0001, op=NAND -> result=0xFFFE, neg=1, parity=1, zero=0. Repeat with op=NOR, a=0x0000, b=0x8000 -> result=0x7FFF, neg=0, parity=1.
- Backpressure: result ready with out_ready=0 for 5 cycles while in_valid=1 with new operands -> result, flags and out_valid held unchanged; in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle; the new operands are accepted only then.
- Reset asserted asynchronously mid-BUSY after slice 2 -> immediately state=IDLE, result=0, flags=0, busy=0. After release, in_ready=1 and no out_valid appears for the aborted operation.
- WIDTH=8, SLICE=8: op=NOT, a=0x3C -> out_valid 1 edge after accept; result=0xC3, neg=1, parity=0, zero=0.
